// File: rtl/pipe_stage.sv
// Valid/ready pipeline stage with a one-entry skid buffer: 1-cycle latency, full throughput,
// in_ready_o decoded from state flops only. Stall counter enabled by PIPE_STAGE_PERF_EN.
module pipe_stage #(
  parameter int unsigned              DATA_W    = 64,
  parameter logic [DATA_W-1:0]        RESET_VAL = {DATA_W{1'b0}},
  parameter int unsigned              CNT_W     = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
`ifdef PIPE_STAGE_PERF_EN
  output logic [CNT_W-1:0]  stall_cnt_o,
`endif
  output logic [DATA_W-1:0] out_data_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;
  logic              acc;
  logic              drn;

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("pipe_stage: CNT_W must be at least 1");
  end

  assign out_valid_o = (state != EMPTY);
  assign in_ready_o  = (state != SKID);
  assign out_data_o  = main_q;

  assign acc = in_valid_i & in_ready_o;
  assign drn = out_valid_o & out_ready_i;

  // Data registers only load on acc or skid->main moves, so an unaccepted
  // in_data_i can never reach out_data_o.
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= EMPTY;
      main_q <= RESET_VAL;
      skid_q <= RESET_VAL;
    end else if (flush_i) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (acc) begin
            state  <= FULL;
            main_q <= in_data_i;
          end
        end
        FULL: begin
          if (acc && drn) begin
            main_q <= in_data_i;
          end else if (acc) begin
            state  <= SKID;
            skid_q <= in_data_i;
          end else if (drn) begin
            state <= EMPTY;
          end
        end
        SKID: begin
          if (drn) begin
            state  <= FULL;
            main_q <= skid_q;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q;

  // Saturating count of cycles where downstream refuses a valid payload.
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (out_valid_o && !out_ready_i && !(&stall_cnt_q)) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage.sv
// Directed bench for pipe_stage: vector table for handshake sequences plus reset and
// stall-counter sequences.
module tb_pipe_stage;
  localparam int unsigned       DATA_W = 64;
  localparam logic [DATA_W-1:0] RVAL   = 64'h13;
  localparam int unsigned       CNT_W  = 3;

  typedef struct {
    logic              iv;
    logic [DATA_W-1:0] id;
    logic              ordy;
    logic              fl;
    logic              exp_ov;
    logic              exp_ir;
    logic [DATA_W-1:0] exp_od;
  } vec_t;

  logic              clock = 1'b0;
  logic              reset;
  logic              flush_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [DATA_W-1:0] in_data_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [DATA_W-1:0] out_data_o;
`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0]  stall_cnt_o;
`endif

  int checks   = 0;
  int failures = 0;
  vec_t vecs[$];

  always #5 clock = ~clock;

  pipe_stage #(.DATA_W(DATA_W), .RESET_VAL(RVAL), .CNT_W(CNT_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .flush_i    (flush_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .in_data_i  (in_data_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
`ifdef PIPE_STAGE_PERF_EN
    .stall_cnt_o(stall_cnt_o),
`endif
    .out_data_o (out_data_o)
  );

  function automatic vec_t mk(input logic iv, input logic [DATA_W-1:0] id, input logic ordy,
                              input logic fl, input logic ov, input logic ir,
                              input logic [DATA_W-1:0] od);
    vec_t v;
    v.iv = iv; v.id = id; v.ordy = ordy; v.fl = fl;
    v.exp_ov = ov; v.exp_ir = ir; v.exp_od = od;
    return v;
  endfunction

  task automatic chk(input string name, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Drive inputs, take one rising edge, sample 1 time unit later.
  task automatic step(input logic rst, input logic iv, input logic [DATA_W-1:0] id,
                      input logic ordy, input logic fl);
    reset = rst; in_valid_i = iv; in_data_i = id; out_ready_i = ordy; flush_i = fl;
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; in_data_i = '0; out_ready_i = 1'b0;

    // Streaming: 0x1..0x10 back-to-back, then drain.
    for (int k = 1; k <= 16; k++) vecs.push_back(mk(1, DATA_W'(k), 1, 0, 1, 1, DATA_W'(k)));
    vecs.push_back(mk(0, 64'h0, 1, 0, 0, 1, 64'h0));
    // Skid: A then B with downstream stalled, a refused push, then in-order drain.
    vecs.push_back(mk(1, 64'hA,  0, 0, 1, 1, 64'hA));
    vecs.push_back(mk(1, 64'hB,  0, 0, 1, 0, 64'hA));
    vecs.push_back(mk(1, 64'h77, 0, 0, 1, 0, 64'hA));
    vecs.push_back(mk(0, 64'h0,  1, 0, 1, 1, 64'hB));
    vecs.push_back(mk(0, 64'h0,  1, 0, 0, 1, 64'h0));
    // Hold stability: 0xDEAD held for 5 stalled cycles while in_data_i changes.
    vecs.push_back(mk(1, 64'hDEAD, 0, 0, 1, 1, 64'hDEAD));
    for (int k = 0; k < 5; k++) vecs.push_back(mk(0, 64'hBAD0 + DATA_W'(k), 0, 0, 1, 1, 64'hDEAD));
    vecs.push_back(mk(0, 64'h0, 1, 0, 0, 1, 64'h0));
    // Flush from SKID with a valid 0xC offered, then 0xD emerges normally.
    vecs.push_back(mk(1, 64'h1A, 0, 0, 1, 1, 64'h1A));
    vecs.push_back(mk(1, 64'h1B, 0, 0, 1, 0, 64'h1A));
    vecs.push_back(mk(1, 64'hC,  0, 1, 0, 1, 64'h0));
    vecs.push_back(mk(1, 64'hD,  1, 0, 1, 1, 64'hD));
    vecs.push_back(mk(0, 64'h0,  1, 0, 0, 1, 64'h0));
    // Flush from FULL beats a real accept of 0xC.
    vecs.push_back(mk(1, 64'h2A, 0, 0, 1, 1, 64'h2A));
    vecs.push_back(mk(1, 64'hC,  0, 1, 0, 1, 64'h0));
    vecs.push_back(mk(0, 64'h0,  0, 0, 0, 1, 64'h0));
    // FULL with simultaneous accept and drain replaces main.
    vecs.push_back(mk(1, 64'h31, 0, 0, 1, 1, 64'h31));
    vecs.push_back(mk(1, 64'h32, 1, 0, 1, 1, 64'h32));
    vecs.push_back(mk(0, 64'h0,  1, 0, 0, 1, 64'h0));

    // Reset from idle.
    step(1, 0, 64'h0, 0, 0);
    chk("reset_ov", 64'(out_valid_o), 64'd0);
    chk("reset_ir", 64'(in_ready_o), 64'd1);
    chk("reset_od", out_data_o, RVAL);

    foreach (vecs[i]) begin
      step(0, vecs[i].iv, vecs[i].id, vecs[i].ordy, vecs[i].fl);
      chk($sformatf("vec%0d_ov", i), 64'(out_valid_o), 64'(vecs[i].exp_ov));
      chk($sformatf("vec%0d_ir", i), 64'(in_ready_o), 64'(vecs[i].exp_ir));
      if (vecs[i].exp_ov) chk($sformatf("vec%0d_od", i), out_data_o, vecs[i].exp_od);
    end

    // Reset while in SKID drops both held entries.
    step(0, 1, 64'h41, 0, 0);
    step(0, 1, 64'h42, 0, 0);
    chk("pre_rst_skid_ir", 64'(in_ready_o), 64'd0);
    step(1, 1, 64'h44, 1, 0);
    chk("skid_rst_ov", 64'(out_valid_o), 64'd0);
    chk("skid_rst_ir", 64'(in_ready_o), 64'd1);
    chk("skid_rst_od", out_data_o, RVAL);
    step(0, 1, 64'h43, 1, 0);
    chk("post_rst_ov", 64'(out_valid_o), 64'd1);
    chk("post_rst_od", out_data_o, 64'h43);
    step(0, 0, 64'h0, 1, 0);
    chk("post_rst_drain_ov", 64'(out_valid_o), 64'd0);

`ifdef PIPE_STAGE_PERF_EN
    step(1, 0, 64'h0, 0, 0);
    chk("perf_rst", 64'(stall_cnt_o), 64'd0);
    step(0, 1, 64'h50, 0, 0);
    chk("perf_first", 64'(stall_cnt_o), 64'd0);
    for (int k = 1; k <= 10; k++) begin
      step(0, 0, 64'h0, 0, 0);
      if (k == 3) chk("perf_mid", 64'(stall_cnt_o), 64'd3);
    end
    chk("perf_sat", 64'(stall_cnt_o), 64'd7);
    step(0, 0, 64'h0, 0, 1);
    chk("perf_flush", 64'(stall_cnt_o), 64'd7);
    step(0, 0, 64'h0, 0, 0);
    chk("perf_idle", 64'(stall_cnt_o), 64'd7);
    step(1, 0, 64'h0, 0, 0);
    chk("perf_clear", 64'(stall_cnt_o), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipe_stage.md
Name: pipe_stage

Overview:
- Generic, parametrised single pipeline stage with a valid/ready handshake on both sides and a one-entry skid buffer.
- Supersedes the hand-written, fixed-field stall/flush stage registers. Each inter-stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB) instantiates one pipe_stage, with stage fields packed into data.
- Backpressure replaces the global stall; full throughput; no combinational path from out_ready_i to in_ready_o.

Parameters:
- DATA_W, 64, width of the packed payload.
- RESET_VAL, {DATA_W{1'b0}}, value loaded into both data registers on reset. Lets IF/ID load NOP/PMEM_START.
- CNT_W, 32, stall counter width; only used when PIPE_STAGE_PERF_EN is defined.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- flush_i  in  1  discard all held entries next edge
- in_valid_i  in  1  upstream payload valid
- in_ready_o  out  1  stage can accept (registered)
- in_data_i  in  DATA_W  upstream payload
- out_valid_o  out  1  payload valid to downstream
- out_ready_i  in  1  downstream accepts
- out_data_o  out  DATA_W  payload to downstream (registered)
- stall_cnt_o  out  CNT_W  only with PIPE_STAGE_PERF_EN

Behaviour:
- Clock and reset: one clock (clock); reset is synchronous and active-high (reset).
- Handshake terms: acc = in_valid_i & in_ready_o; drn = out_valid_o & out_ready_i.
- Storage: main register (drives out_data_o) plus one skid register.
- States:
  - EMPTY: main invalid.
  - FULL: main valid, skid invalid.
  - SKID: both valid.
- Outputs by state:
  - out_valid_o = (state != EMPTY).
  - in_ready_o = (state != SKID). Decoded from state flops only.
- EMPTY: acc -> FULL, main <= in_data_i.
- FULL:
  - acc & drn -> FULL, main <= in_data_i.
  - acc & !drn -> SKID, skid <= in_data_i.
  - !acc & drn -> EMPTY.
  - neither -> hold.
- SKID (no acc possible):
  - drn -> FULL, main <= skid (older entry first; order always preserved).
  - else hold.
- Latency: accepted payload appears on out_data_o/out_valid_o the cycle after acc. Sustained throughput is 1 per cycle when out_ready_i=1.
- Stability: while out_valid_o & !out_ready_i, out_data_o and out_valid_o hold unchanged.
- No in_valid_i-before-in_ready_o dependency: a producer may assert valid regardless of ready.
- Flush:
  - flush_i=1 -> next state EMPTY, out_valid_o=0, in_ready_o=1.
  - Any acc in the flush cycle is discarded, so flush beats accept.
  - A drn in the flush cycle is a completed transfer (downstream took it).
  - Data registers not cleared by flush (don't-care while invalid).
- Reset: state EMPTY, out_valid_o=0, in_ready_o=1, main=skid=RESET_VAL, stall_cnt_o=0. Reset overrides flush and all handshakes.
- Reset mid-operation: held entries are lost; identical to reset from idle.
- An X on in_data_i must never propagate to out_data_o unless accepted.

Optional Feature:
- Macro PIPE_STAGE_PERF_EN.
- Defined:
  - Adds stall_cnt_o.
  - Increments each cycle out_valid_o & !out_ready_i; saturates at all-ones (no wrap).
  - Cleared only by reset; flush does not clear it.
- Undefined: port and counter logic absent; all other behaviour identical.

Test Plan:
- Streaming: DATA_W=64, out_ready_i=1, push 0x1..0x10 back-to-back -> out_data_o 0x1..0x10 one cycle delayed, in_ready_o never low, no gaps.
- Skid: push A=0xA, B=0xB on consecutive cycles with out_ready_i=0 -> FULL then SKID, in_ready_o=0 on cycle 3. Raise out_ready_i -> A then B delivered in order, in_ready_o returns high the cycle after A drains.
- Hold stability: out_ready_i=0 for 5 cycles with payload 0xDEAD -> out_data_o=0xDEAD, out_valid_o=1 constant all 5 cycles.
- Flush priority: SKID state plus flush_i=1 with in_valid_i=1 data 0xC -> next cycle out_valid_o=0, in_ready_o=1. 0xC never emitted; following push 0xD emerges normally.
- Reset: reset asserted in SKID state with RESET_VAL=0x13 -> next cycle out_valid_o=0, in_ready_o=1, out_data_o=0x13.
- Perf (PIPE_STAGE_PERF_EN, CNT_W=3): hold a valid with out_ready_i=0 for 10 cycles -> stall_cnt_o reaches 7 and stays 7. A flush does not clear it; reset returns it to 0.
